silife_grid_loader_ml: RTL and testbench
========================================

SILIFE_GRID_LOADER_ML -- requirements
Module: silife_grid_loader_ml

Interface
REQ-001 SHALL have parameter WIDTH, default 32, cells per row; legal values are multiples of LANES, 8..64.
REQ-002 SHALL have parameter HEIGHT, default 32, rows per segment; ROW_BITS = $clog2(HEIGHT).
REQ-003 SHALL have parameter LANES, default 1, cell-data bits per clock; legal values are 1, 2, 4.
REQ-004 SHALL have port i_load_clk  input  1  load clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_load_cs  input  1  frame select, active-low (high = deselected), asynchronous frame abort.
REQ-007 SHALL have port i_load_data  input  LANES  serial data; lane 0 carries all header bits.
REQ-008 SHALL have port o_load_data  output  1  daisy-chain output: 1 while state=CONFIG, else combinational i_load_data[0].
REQ-009 SHALL have port o_row_wr  output  1  one-clock row write strobe.
REQ-010 SHALL have port o_row_select  output  ROW_BITS  target row, valid with o_row_wr.
REQ-011 SHALL have port o_row_data  output  WIDTH  row cell values, valid with o_row_wr.
REQ-012 SHALL have port o_err  output  1  sticky frame error flag.
REQ-013 SHALL have port o_local_address  output  15  device address assigned in CONFIG.

Function
REQ-014 SHALL implement states IDLE, CONFIG, CFG_DONE, SEG_ADDR, ROW_ADDR, CELLS, PARITY.
REQ-015 In IDLE, first clock with cs low: lane0=1 -> CONFIG, local_address<=0; lane0=0 -> SEG_ADDR, bit counter<=14.
REQ-016 In CONFIG, each lane0=1 increments local_address (wraps 0x7FFF->0); lane0=0 -> CFG_DONE, which ignores all bits until cs deasserts.
REQ-017 SEG_ADDR SHALL shift 15 lane0 bits MSB first into segment; ROW_ADDR then shifts 16 bits MSB first into row; then -> CELLS.
REQ-018 CELLS SHALL accept LANES bits per clock, lane k -> cell index (cnt-LANES+1+k), cnt starting WIDTH-1 and falling by LANES; a row completes after WIDTH/LANES clocks.
REQ-019 Device is selected when segment==local_address or segment==0x7FFF.
REQ-020 On row completion (after PARITY when enabled), if selected and no error, o_row_wr SHALL pulse for exactly the following clock with o_row_data and o_row_select=row[ROW_BITS-1:0]; latency 1 clock after the last cell bit.
REQ-021 After each row, row SHALL increment; when row[ROW_BITS-1:0]==HEIGHT-1 it wraps to 0; CELLS restarts without a new header.
REQ-022 Unselected devices SHALL still count bits and rows but never pulse o_row_wr.
REQ-023 cs deasserting (high) SHALL asynchronously return to IDLE, clear bit counter, segment, row, partial row buffer and o_err; local_address is retained; a partial row is discarded.
REQ-024 cs low with no i_load_clk edges SHALL cause no state change.

Reset
REQ-025 reset SHALL asynchronously force IDLE, local_address=0, segment=0, row=0, o_row_wr=0, o_row_select=0, o_row_data=0, o_err=0.
REQ-026 reset SHALL take priority over cs and clock; first valid edge is the first rising i_load_clk after reset deasserts.

Configuration
REQ-027 Macro SILIFE_LOADER_PARITY_EN: when defined, each row SHALL be followed by one PARITY clock whose lane0 bit makes row bits plus parity even; on mismatch the row is not written and o_err sets until cs deasserts or reset.
REQ-028 Without SILIFE_LOADER_PARITY_EN, PARITY state and o_err logic SHALL be absent, o_err tied 0, and the row writes directly after CELLS.

Verification
REQ-029 Reset, cs low, lane0 = 1,1,1,1,0 -> o_local_address=3, o_load_data=1 during CONFIG clocks, CFG_DONE until cs high.
REQ-030 local_address=3, WIDTH=32, LANES=1: segment 3, row 5, data 0xA5A5_0F0F -> one o_row_wr pulse, o_row_select=5, o_row_data=0xA5A5_0F0F.
REQ-031 LANES=4, segment 0x7FFF, row HEIGHT-1, two rows -> writes to row 31 then row 0 (wrap), 8 clocks per row.
REQ-032 Segment 2 on device with local_address 3 -> no o_row_wr, row counter still advances.
REQ-033 cs high after 10 of 32 cell bits, then new frame row 0 -> no write for aborted row, new row written correctly.
REQ-034 PARITY_EN defined, wrong parity bit -> no o_row_wr, o_err=1; cs high -> o_err=0.

Source files
------------

// File: rtl/silife_grid_loader_ml.sv
// Serial loader for one segment of a Life cell grid: address config, header decode, row assembly.
// Optional SILIFE_LOADER_PARITY_EN appends an even-parity bit to every row and drives a sticky o_err.
module silife_grid_loader_ml #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int LANES  = 1
) (
  input  logic                        i_load_clk,
  input  logic                        reset,
  input  logic                        i_load_cs,
  input  logic [LANES-1:0]            i_load_data,
  output logic                        o_load_data,
  output logic                        o_row_wr,
  output logic [$clog2(HEIGHT)-1:0]   o_row_select,
  output logic [WIDTH-1:0]            o_row_data,
  output logic                        o_err,
  output logic [14:0]                 o_local_address
);

  localparam int ROW_BITS = $clog2(HEIGHT);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CONFIG   = 3'd1;
  localparam logic [2:0] CFG_DONE = 3'd2;
  localparam logic [2:0] SEG_ADDR = 3'd3;
  localparam logic [2:0] ROW_ADDR = 3'd4;
  localparam logic [2:0] CELLS    = 3'd5;
  localparam logic [2:0] PARITY   = 3'd6;

  localparam logic [5:0]          CNT_TOP   = 6'(WIDTH - 1);
  localparam logic [5:0]          CNT_LAST  = 6'(LANES - 1);
  localparam logic [5:0]          CNT_STEP  = 6'(LANES);
  localparam logic [14:0]         BROADCAST = 15'h7FFF;
  localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(HEIGHT - 1);

  logic [2:0]       state;
  logic [5:0]       cnt;
  logic [14:0]      segment;
  logic [15:0]      row;
  logic [WIDTH-1:0] row_buf;
  logic [14:0]      local_address;

  logic             lane0;
  logic             selected;
  logic             cells_last;
  logic [WIDTH-1:0] row_next;
  logic [15:0]      row_inc;
  logic             write_now;
  logic [WIDTH-1:0] write_data;

  assign lane0      = i_load_data[0];
  assign selected   = (segment == local_address) || (segment == BROADCAST);
  assign cells_last = (cnt == CNT_LAST);
  // Cells arrive highest index first, so shifting left lands lane k at index cnt-LANES+1+k.
  assign row_next   = {row_buf[WIDTH-LANES-1:0], i_load_data};

  assign o_load_data     = (state == CONFIG) ? 1'b1 : lane0;
  assign o_local_address = local_address;

`ifdef SILIFE_LOADER_PARITY_EN
  logic err;
  logic parity_ok;

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  assign parity_ok = (even_parity(row_buf) == lane0);
  assign o_err     = err;

  // Sticky parity error, cleared only by reset or frame end.
  always_ff @(posedge i_load_clk or posedge reset or posedge i_load_cs) begin
    if (reset) begin
      err <= 1'b0;
    end else if (i_load_cs) begin
      err <= 1'b0;
    end else if ((state == PARITY) && !parity_ok) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`else
  assign o_err = 1'b0;
`endif

  // Next row index, wrapping at the last row of the segment.
  always_comb begin
    if (row[ROW_BITS-1:0] == ROW_LAST) begin
      row_inc = 16'd0;
    end else begin
      row_inc = row + 16'd1;
    end
  end

  // Decide whether the current edge completes a row that must be written.
  always_comb begin
    write_now  = 1'b0;
    write_data = row_buf;
    case (state)
`ifdef SILIFE_LOADER_PARITY_EN
      PARITY:  write_now = selected && !err && parity_ok;
`else
      CELLS: begin
        write_now  = selected && cells_last;
        write_data = row_next;
      end
`endif
      default: write_now = 1'b0;
    endcase
  end

  // Frame state machine; a deselect aborts the frame asynchronously.
  always_ff @(posedge i_load_clk or posedge reset or posedge i_load_cs) begin
    if (reset || i_load_cs) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      segment <= 15'd0;
      row     <= 16'd0;
      row_buf <= {WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (lane0) begin
            state <= CONFIG;
          end else begin
            state <= SEG_ADDR;
            cnt   <= 6'd14;
          end
        end
        CONFIG: begin
          if (!lane0) begin
            state <= CFG_DONE;
          end else begin
            state <= CONFIG;
          end
        end
        CFG_DONE: state <= CFG_DONE;
        SEG_ADDR: begin
          segment <= {segment[13:0], lane0};
          if (cnt == 6'd0) begin
            state <= ROW_ADDR;
            cnt   <= 6'd15;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        ROW_ADDR: begin
          row <= {row[14:0], lane0};
          if (cnt == 6'd0) begin
            state <= CELLS;
            cnt   <= CNT_TOP;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        CELLS: begin
          row_buf <= row_next;
          if (cells_last) begin
`ifdef SILIFE_LOADER_PARITY_EN
            state <= PARITY;
`else
            row <= row_inc;
            cnt <= CNT_TOP;
`endif
          end else begin
            cnt <= cnt - CNT_STEP;
          end
        end
`ifdef SILIFE_LOADER_PARITY_EN
        PARITY: begin
          state <= CELLS;
          row   <= row_inc;
          cnt   <= CNT_TOP;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Device address survives frame aborts; only reset clears it.
  always_ff @(posedge i_load_clk or posedge reset) begin
    if (reset) begin
      local_address <= 15'd0;
    end else if (!i_load_cs && (state == IDLE) && lane0) begin
      local_address <= 15'd0;
    end else if (!i_load_cs && (state == CONFIG) && lane0) begin
      local_address <= local_address + 15'd1;
    end else begin
      local_address <= local_address;
    end
  end

  // Registered row write port.
  always_ff @(posedge i_load_clk or posedge reset) begin
    if (reset) begin
      o_row_wr     <= 1'b0;
      o_row_select <= {ROW_BITS{1'b0}};
      o_row_data   <= {WIDTH{1'b0}};
    end else if (write_now) begin
      o_row_wr     <= 1'b1;
      o_row_select <= row[ROW_BITS-1:0];
      o_row_data   <= write_data;
    end else begin
      o_row_wr     <= 1'b0;
      o_row_select <= o_row_select;
      o_row_data   <= o_row_data;
    end
  end

endmodule

// File: tb/tb_silife_grid_loader_ml.sv
// Directed bench: device A (LANES=1) for config/write/abort/parity, device B (LANES=4) for broadcast and row wrap.
module tb_silife_grid_loader_ml;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_cs, b_cs;
  logic [0:0]  a_data;
  logic [3:0]  b_data;

  logic        a_load_data, a_row_wr, a_err;
  logic [4:0]  a_row_select;
  logic [31:0] a_row_data;
  logic [14:0] a_local_address;
  logic        b_load_data, b_row_wr, b_err;
  logic [4:0]  b_row_select;
  logic [31:0] b_row_data;
  logic [14:0] b_local_address;

  int checks = 0;
  int errors = 0;
  int a_wr_cnt = 0;
  int b_wr_cnt = 0;

`ifdef SILIFE_LOADER_PARITY_EN
  localparam logic WR_AFTER_CELLS = 1'b0;
`else
  localparam logic WR_AFTER_CELLS = 1'b1;
`endif

  silife_grid_loader_ml #(.WIDTH(32), .HEIGHT(32), .LANES(1)) u_a (
    .i_load_clk(clk), .reset(reset), .i_load_cs(a_cs), .i_load_data(a_data),
    .o_load_data(a_load_data), .o_row_wr(a_row_wr), .o_row_select(a_row_select),
    .o_row_data(a_row_data), .o_err(a_err), .o_local_address(a_local_address)
  );

  silife_grid_loader_ml #(.WIDTH(32), .HEIGHT(32), .LANES(4)) u_b (
    .i_load_clk(clk), .reset(reset), .i_load_cs(b_cs), .i_load_data(b_data),
    .o_load_data(b_load_data), .o_row_wr(b_row_wr), .o_row_select(b_row_select),
    .o_row_data(b_row_data), .o_err(b_err), .o_local_address(b_local_address)
  );

  // Count write pulses a little after the falling edge.
  always @(negedge clk) begin
    #2;
    if (a_row_wr) a_wr_cnt++;
    if (b_row_wr) b_wr_cnt++;
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_bit(input logic b);
    a_data = b;
    @(negedge clk);
  endtask

  task automatic a_header(input logic [14:0] seg, input logic [15:0] rw);
    a_cs = 1'b0;
    a_bit(1'b0);
    for (int i = 14; i >= 0; i--) a_bit(seg[i]);
    for (int i = 15; i >= 0; i--) a_bit(rw[i]);
  endtask

  task automatic a_cells(input logic [31:0] d, input int n);
    for (int i = 31; i > 31 - n; i--) a_bit(d[i]);
  endtask

  task automatic a_parity(input logic p);
`ifdef SILIFE_LOADER_PARITY_EN
    a_bit(p);
`else
    a_data = p;
`endif
  endtask

  task automatic a_idle();
    a_cs = 1'b1;
    a_data = 1'b0;
    @(negedge clk);
  endtask

  task automatic b_bit(input logic b);
    b_data = {3'b000, b};
    @(negedge clk);
  endtask

  task automatic b_header(input logic [14:0] seg, input logic [15:0] rw);
    b_cs = 1'b0;
    b_bit(1'b0);
    for (int i = 14; i >= 0; i--) b_bit(seg[i]);
    for (int i = 15; i >= 0; i--) b_bit(rw[i]);
  endtask

  task automatic b_nib(input logic [31:0] d, input int j);
    b_data = d[31-4*j -: 4];
    @(negedge clk);
  endtask

  task automatic b_parity(input logic p);
`ifdef SILIFE_LOADER_PARITY_EN
    b_bit(p);
`else
    b_data = {3'b000, p};
`endif
  endtask

  initial begin
    logic [31:0] d;
    reset  = 1'b1;
    a_cs   = 1'b1;
    b_cs   = 1'b1;
    a_data = 1'b0;
    b_data = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_value("rst_row_wr", a_row_wr, 0);
    check_value("rst_row_select", a_row_select, 0);
    check_value("rst_row_data", a_row_data, 0);
    check_value("rst_err", a_err, 0);
    check_value("rst_local_address", a_local_address, 0);
    check_value("rst_b_local_address", b_local_address, 0);

    // Address configuration: 1,1,1,1,0 leaves address 3.
    a_cs = 1'b0;
    repeat (4) a_bit(1'b1);
    a_data = 1'b0;
    #1 check_value("cfg_dout_forced", a_load_data, 1);
    @(negedge clk);
    a_data = 1'b1;
    #1 check_value("cfgdone_dout_hi", a_load_data, 1);
    a_data = 1'b0;
    #1 check_value("cfgdone_dout_lo", a_load_data, 0);
    check_value("cfg_address", a_local_address, 3);
    a_bit(1'b1);
    a_bit(1'b1);
    check_value("cfgdone_ignores", a_local_address, 3);
    a_idle();
    check_value("address_retained", a_local_address, 3);

    // Selected row write, segment 3 row 5.
    d = 32'hA5A5_0F0F;
    a_header(15'd3, 16'd5);
    a_cells(d, 31);
    check_value("no_early_wr", a_row_wr, 0);
    a_bit(d[0]);
    check_value("wr_latency", a_row_wr, WR_AFTER_CELLS);
    a_parity(^d);
    check_value("wr_pulse", a_row_wr, 1);
    check_value("wr_select", a_row_select, 5);
    check_value("wr_data", a_row_data, 32'hA5A5_0F0F);
    a_bit(1'b0);
    check_value("wr_one_clock", a_row_wr, 0);
    a_idle();
    check_value("wr_count_sel", a_wr_cnt, 1);

    // Unselected segment: no write, row counter still advances.
    d = 32'h0F0F_3C3C;
    a_header(15'd2, 16'd7);
    a_cells(d, 32);
    a_parity(^d);
    check_value("unsel_row_adv", u_a.row, 8);
    a_bit(1'b0);
    check_value("unsel_no_wr", a_wr_cnt, 1);
    a_idle();
    check_value("abort_clears_row", u_a.row, 0);

    // Abort mid-row, then a fresh frame to row 0.
    a_header(15'd3, 16'd9);
    a_cells(32'hFFFF_FFFF, 10);
    a_idle();
    d = 32'h1234_5678;
    a_header(15'd3, 16'd0);
    a_cells(d, 32);
    a_parity(^d);
    check_value("abort_new_wr", a_row_wr, 1);
    check_value("abort_new_select", a_row_select, 0);
    check_value("abort_new_data", a_row_data, 32'h1234_5678);
    a_idle();
    check_value("abort_wr_count", a_wr_cnt, 2);

`ifdef SILIFE_LOADER_PARITY_EN
    // Bad parity: no write, sticky error until deselect.
    d = 32'hCAFE_F00D;
    a_header(15'd3, 16'd1);
    a_cells(d, 32);
    a_parity(~^d);
    check_value("par_no_wr", a_row_wr, 0);
    check_value("par_err_set", a_err, 1);
    a_bit(1'b0);
    check_value("par_err_sticky", a_err, 1);
    a_idle();
    check_value("par_err_clear", a_err, 0);
    check_value("par_wr_count", a_wr_cnt, 2);
`endif

    // Four-lane broadcast into the last row, then wrap to row 0.
    d = 32'hDEAD_BEEF;
    b_header(15'h7FFF, 16'd31);
    for (int j = 0; j < 7; j++) b_nib(d, j);
    check_value("b_no_early_wr", b_row_wr, 0);
    b_nib(d, 7);
    check_value("b_8_clocks", b_row_wr, WR_AFTER_CELLS);
    b_parity(^d);
    check_value("b_wr_last", b_row_wr, 1);
    check_value("b_sel_last", b_row_select, 31);
    check_value("b_data_last", b_row_data, 32'hDEAD_BEEF);
    d = 32'h0123_4567;
    for (int j = 0; j < 8; j++) b_nib(d, j);
    b_parity(^d);
    check_value("b_wr_wrap", b_row_wr, 1);
    check_value("b_sel_wrap", b_row_select, 0);
    check_value("b_data_wrap", b_row_data, 32'h0123_4567);
    b_cs = 1'b1;
    b_data = 4'h0;
    @(negedge clk);
    check_value("b_wr_count", b_wr_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
